// File: rtl/reset_sequencer_if.sv
// Lock/soft-reset inputs and staged reset outputs of reset_sequencer.
// Combinational bundle; no latency, no backpressure.
interface reset_sequencer_if;
   logic LOCKED;
   logic SOFT_RST;
   logic PRE;
   logic PROC_RST;
   logic READY;

   modport master (output LOCKED, output SOFT_RST,
                   input  PRE, input PROC_RST, input READY);
   modport slave  (input  LOCKED, input SOFT_RST,
                   output PRE, output PROC_RST, output READY);
endinterface

// File: rtl/reset_sequencer.sv
// Staged KCPSM3 reset: async assert, PRE released STRETCH_CYCLES after lock, PROC_RST STAGGER_CYCLES later.
// Outputs registered from next state (1-cycle); no backpressure, SOFT_RST is a one-cycle strobe.
module reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input logic          C,
   input logic          RST_N,
   reset_sequencer_if.slave bus
);
   localparam int MAX_CYC = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   localparam logic [2:0] HOLD      = 3'd0;
   localparam logic [2:0] WAIT_LOCK = 3'd1;
   localparam logic [2:0] STRETCH   = 3'd2;
   localparam logic [2:0] STAGGER   = 3'd3;
   localparam logic [2:0] RUN       = 3'd4;

   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pre_q, proc_rst_q, ready_q;
   logic                   rst_sync;
   logic                   locked_sync;

   assign rst_sync    = rst_sync_q[SYNC_STAGES-1];
   assign locked_sync = lock_sync_q[SYNC_STAGES-1];

   always_ff @(posedge C or negedge RST_N) begin
      if (!RST_N) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.LOCKED};
      end
   end

   // Lock loss is tested first in every locked state so it outranks SOFT_RST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         HOLD: begin
            if (rst_sync) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_sync) state_d = STRETCH;
         end
         STRETCH: begin
            if (!locked_sync)              state_d = WAIT_LOCK;
            else if (cnt_q == STRETCH_LAST) state_d = STAGGER;
            else                            cnt_d   = cnt_q + CNT_ONE;
         end
         STAGGER: begin
            if (!locked_sync)              state_d = WAIT_LOCK;
            else if (bus.SOFT_RST)          state_d = STRETCH;
            else if (cnt_q == STAGGER_LAST) state_d = RUN;
            else                            cnt_d   = cnt_q + CNT_ONE;
         end
         RUN: begin
            if (!locked_sync)      state_d = WAIT_LOCK;
            else if (bus.SOFT_RST) state_d = STRETCH;
         end
         default: state_d = HOLD;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge C or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         pre_q      <= 1'b1;
         proc_rst_q <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pre_q      <= (state_d == HOLD) || (state_d == WAIT_LOCK) || (state_d == STRETCH);
         proc_rst_q <= (state_d != RUN);
         ready_q    <= (state_d == RUN);
      end
   end

   assign bus.PRE      = pre_q;
   assign bus.PROC_RST = proc_rst_q;
   assign bus.READY    = ready_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected {PRE,PROC_RST,READY} values are queued
// against absolute edge numbers and compared when the bench reaches that edge.
module tb_reset_sequencer;
   typedef struct {
      int         edge_n;
      logic [2:0] val;
      string      tag;
   } exp_t;

   logic C;
   logic RST_N;
   reset_sequencer_if sif ();

   reset_sequencer #(
      .SYNC_STAGES    (2),
      .STRETCH_CYCLES (16),
      .STAGGER_CYCLES (4)
   ) dut (
      .C     (C),
      .RST_N (RST_N),
      .bus   (sif.slave)
   );

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_cnt = 0;

   initial begin
      C = 1'b0;
      forever #5 C = ~C;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   function automatic logic [2:0] outs();
      return {sif.PRE, sif.PROC_RST, sif.READY};
   endfunction

   task automatic push(input int e, input logic [2:0] v, input string tag);
      exp_t x;
      x.edge_n = e;
      x.val    = v;
      x.tag    = tag;
      exp_q.push_back(x);
   endtask

   task automatic step();
      exp_t x;
      @(posedge C);
      #1;
      edge_cnt++;
      while (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
         x = exp_q.pop_front();
         chk(x.tag, {29'd0, outs()}, {29'd0, x.val});
      end
   endtask

   task automatic run_to(input int target);
      while (edge_cnt < target) step();
   endtask

   // Assert reset between clock edges, confirm the async values, then release before a new edge 1.
   task automatic do_reset(input string tag);
      RST_N = 1'b0;
      #1;
      chk(tag, {29'd0, outs()}, {29'd0, 3'b110});
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (3) @(posedge C);
      @(negedge C);
      RST_N    = 1'b1;
      edge_cnt = 0;
   endtask

   initial begin
      RST_N        = 1'b0;
      sif.LOCKED   = 1'b1;
      sif.SOFT_RST = 1'b0;
      #13;

      // Power-up with lock stable
      do_reset("rst_pwrup");
      push(1,  3'b110, "pwr_e1");
      push(19, 3'b110, "pwr_pre_hold19");
      push(20, 3'b010, "pwr_pre_fall20");
      push(23, 3'b010, "pwr_ready_low23");
      push(24, 3'b001, "pwr_run24");
      run_to(26);

      // Late lock: LOCKED rises after edge 30
      #2;
      do_reset("rst_late_lock");
      sif.LOCKED = 1'b0;
      push(24, 3'b110, "late_wait24");
      push(30, 3'b110, "late_wait30");
      run_to(30);
      sif.LOCKED = 1'b1;
      push(48, 3'b110, "late_pre_hold48");
      push(49, 3'b010, "late_pre_fall49");
      push(52, 3'b010, "late_ready_low52");
      push(53, 3'b001, "late_run53");
      run_to(55);

      // Lock pulsed low for 3 cycles in RUN
      sif.LOCKED = 1'b0;
      push(57, 3'b001, "lk_still_run57");
      push(58, 3'b110, "lk_reassert58");
      run_to(58);
      sif.LOCKED = 1'b1;
      push(76, 3'b110, "lk_pre_hold76");
      push(77, 3'b010, "lk_pre_fall77");
      push(80, 3'b010, "lk_ready_low80");
      push(81, 3'b001, "lk_run81");
      run_to(83);

      // SOFT_RST single-cycle pulse in RUN
      sif.SOFT_RST = 1'b1;
      push(84, 3'b110, "soft_reassert84");
      run_to(84);
      sif.SOFT_RST = 1'b0;
      push(99,  3'b110, "soft_pre_hold99");
      push(100, 3'b010, "soft_pre_fall100");
      push(103, 3'b010, "soft_ready_low103");
      push(104, 3'b001, "soft_run104");
      run_to(106);

      // One-edge lock dip coinciding with SOFT_RST: lock loss must win
      sif.LOCKED = 1'b0;
      run_to(107);
      sif.LOCKED = 1'b1;
      run_to(108);
      sif.SOFT_RST = 1'b1;
      push(109, 3'b110, "prio_reassert109");
      run_to(109);
      sif.SOFT_RST = 1'b0;
      push(125, 3'b110, "prio_pre_hold125");
      push(126, 3'b010, "prio_pre_fall126");
      push(129, 3'b010, "prio_ready_low129");
      push(130, 3'b001, "prio_run130");
      run_to(131);

      // RST_N mid-STRETCH, then full restart from edge 1
      sif.SOFT_RST = 1'b1;
      run_to(132);
      sif.SOFT_RST = 1'b0;
      push(140, 3'b110, "mid_stretch140");
      run_to(140);
      #3;
      do_reset("rst_mid_stretch");
      push(19, 3'b110, "re_pre_hold19");
      push(20, 3'b010, "re_pre_fall20");
      push(24, 3'b001, "re_run24");
      run_to(26);
      chk("final_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
      $fatal(1);
   end
endmodule
